// File: rtl/instruction_fetch_pkg.sv
// Shared CPU constants for the fetch stage.
//   RESET_PC  : first byte address fetched after reset
//   END_WORD  : instruction word that marks end of program
//   PC_INC    : sequential pc step in bytes
//   ST_*      : fetch FSM state encoding
//   fetch_pkt_t : instruction word plus its byte address
package instruction_fetch_pkg;

   localparam logic [31:0] RESET_PC = 32'd0;
   localparam logic [31:0] END_WORD = 32'd0;
   localparam logic [31:0] PC_INC   = 32'd4;

   localparam logic [0:0] ST_FETCH = 1'b0;
   localparam logic [0:0] ST_DONE  = 1'b1;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_pkt_t;

   // Force a byte address onto a word boundary.
   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_out_reg.sv
// Valid/ready output register for the fetch stage.
//   clk, reset : clock, synchronous active-high reset
//   load       : capture in_pkt and mark valid (wins over clear)
//   clear      : drop valid, keep the payload bits
//   in_pkt     : instruction/pc to capture
//   out_valid  : register holds an instruction
//   out_pkt    : registered instruction/pc
// With neither load nor clear the register holds, which is how a
// stalled consumer (out_ready=0) keeps its instruction stable.
module fetch_out_reg
   import instruction_fetch_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic       clear,
   input  fetch_pkt_t in_pkt,
   output logic       out_valid,
   output fetch_pkt_t out_pkt
);

   logic       valid_q, valid_d;
   fetch_pkt_t pkt_q, pkt_d;

   always_comb begin
      valid_d = valid_q;
      pkt_d   = pkt_q;
      if (load) begin
         valid_d = 1'b1;
         pkt_d   = in_pkt;
      end else if (clear) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         pkt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         pkt_q   <= pkt_d;
      end
   end

   assign out_valid = valid_q;
   assign out_pkt   = pkt_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: pc register, FETCH/DONE FSM, branch redirect,
// end-of-program detection and accepted-instruction counter.
//   clk, reset              : clock, synchronous active-high reset
//   imem_addr / imem_data   : combinational instruction memory port
//   branch_valid/_target    : one-cycle redirect request
//   out_valid/out_ready     : handshake to the consumer
//   out_instr/out_pc/out_pc8: fetched word, its address, address+8
//   done                    : end marker reached, fetch halted
//   misalign                : sticky, a branch target was not word aligned
//   fetch_count             : saturating count of accepted instructions
module instruction_fetch
   import instruction_fetch_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   input  logic        branch_valid,
   input  logic [31:0] branch_target,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic [31:0] out_pc8,
   output logic        done,
   output logic        misalign,
   output logic [15:0] fetch_count
);

   logic [31:0] pc_q, pc_d;
   logic [0:0]  state_q, state_d;
   logic        done_q, done_d;
   logic        misalign_q, misalign_d;
   logic [15:0] fetch_count_q, fetch_count_d;

   logic       capture, is_end, load, clear, accept;
   fetch_pkt_t in_pkt, out_pkt;

   // Output register is free when empty or being drained this edge.
   assign capture = (state_q == ST_FETCH) && !branch_valid && (!out_valid || out_ready);
   assign is_end  = (imem_data == END_WORD);
   assign load    = capture && !is_end;
   assign accept  = out_valid && out_ready;
   // Any drain that is not refilled empties the register; a branch
   // discards whatever is held.
   assign clear   = branch_valid || accept;

   assign in_pkt.instr = imem_data;
   assign in_pkt.pc    = pc_q;

   always_comb begin
      pc_d          = pc_q;
      state_d       = state_q;
      done_d        = done_q;
      misalign_d    = misalign_q;
      fetch_count_d = fetch_count_q;

      if (branch_valid) begin
         pc_d    = align_word(branch_target);
         state_d = ST_FETCH;
         done_d  = 1'b0;
         if (branch_target[1:0] != 2'b00)
            misalign_d = 1'b1;
      end else begin
         if (capture) begin
            if (is_end) begin
               // pc parks on the marker so imem_addr shows where we stopped.
               state_d = ST_DONE;
               done_d  = 1'b1;
            end else begin
               pc_d = pc_q + PC_INC;
            end
         end
         if (accept && fetch_count_q != 16'hFFFF)
            fetch_count_d = fetch_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q          <= RESET_PC;
         state_q       <= ST_FETCH;
         done_q        <= 1'b0;
         misalign_q    <= 1'b0;
         fetch_count_q <= 16'd0;
      end else begin
         pc_q          <= pc_d;
         state_q       <= state_d;
         done_q        <= done_d;
         misalign_q    <= misalign_d;
         fetch_count_q <= fetch_count_d;
      end
   end

   fetch_out_reg u_out_reg (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .clear     (clear),
      .in_pkt    (in_pkt),
      .out_valid (out_valid),
      .out_pkt   (out_pkt)
   );

   assign imem_addr   = pc_q;
   assign out_instr   = out_pkt.instr;
   assign out_pc      = out_pkt.pc;
   assign out_pc8     = out_pkt.pc + 32'd8;
   assign done        = done_q;
   assign misalign    = misalign_q;
   assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch using the program memory model.
module tb_instruction_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] imem_addr, imem_data;
   logic        branch_valid;
   logic [31:0] branch_target;
   logic        out_valid, out_ready;
   logic [31:0] out_instr, out_pc, out_pc8;
   logic        done, misalign;
   logic [15:0] fetch_count;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   instruction_fetch dut (
      .clk           (clk),
      .reset         (reset),
      .imem_addr     (imem_addr),
      .imem_data     (imem_data),
      .branch_valid  (branch_valid),
      .branch_target (branch_target),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_instr     (out_instr),
      .out_pc        (out_pc),
      .out_pc8       (out_pc8),
      .done          (done),
      .misalign      (misalign),
      .fetch_count   (fetch_count)
   );

   // Program memory: listed words, everything else a nonzero filler.
   function automatic logic [31:0] mem(input logic [31:0] a);
      case (a)
         32'd0:   return 32'hE2099F00;
         32'd4:   return 32'hE3811F06;
         32'd60:  return 32'h1AFFFFFB;
         32'd64:  return 32'hE5A90008;
         32'd68:  return 32'h00000000;
         default: return 32'hE1A00000 | a;
      endcase
   endfunction

   assign imem_data = mem(imem_addr);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; branch_valid = 1'b0; branch_target = '0; out_ready = 1'b1;
      tick(); tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; branch_valid = 1'b1; branch_target = 32'h0000_0040; out_ready = 1'b1;
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%h exp=0", out_valid); end
      checks++; if (imem_addr !== 32'd0) begin errors++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
      checks++; if ({out_instr, out_pc} !== 64'd0) begin errors++; $display("FAIL reset_out got=%h/%h exp=0/0", out_instr, out_pc); end
      checks++; if ({done, misalign, fetch_count} !== 18'd0) begin errors++; $display("FAIL reset_flags got=%b/%b/%0d exp=0/0/0", done, misalign, fetch_count); end
      branch_valid = 1'b0;
      reset = 1'b0;
   endtask

   task automatic test_first_fetch();
      do_reset();
      tick();
      checks++; if ({out_valid, out_instr, out_pc, out_pc8} !== {1'b1, 32'hE2099F00, 32'd0, 32'd8})
         begin errors++; $display("FAIL first_fetch got=%b %h %h %h exp=1 e2099f00 0 8", out_valid, out_instr, out_pc, out_pc8); end
      tick();
      checks++; if ({out_valid, out_instr, out_pc} !== {1'b1, 32'hE3811F06, 32'd4})
         begin errors++; $display("FAIL second_fetch got=%b %h %h exp=1 e3811f06 4", out_valid, out_instr, out_pc); end
      checks++; if (fetch_count !== 16'd1) begin errors++; $display("FAIL count_after_two got=%0d exp=1", fetch_count); end
   endtask

   task automatic test_stall();
      // Continues from test_first_fetch: E3811F06 held, count=1.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if ({out_valid, out_instr, out_pc, imem_addr, fetch_count} !== {1'b1, 32'hE3811F06, 32'd4, 32'd8, 16'd1})
            begin errors++; $display("FAIL stall_hold[%0d] got=%b %h %h %h %0d exp=1 e3811f06 4 8 1", i, out_valid, out_instr, out_pc, imem_addr, fetch_count); end
      end
      out_ready = 1'b1;
      tick();
      checks++; if ({fetch_count, out_pc, out_instr} !== {16'd2, 32'd8, 32'hE1A00008})
         begin errors++; $display("FAIL stall_release got=%0d %h %h exp=2 8 e1a00008", fetch_count, out_pc, out_instr); end
   endtask

   task automatic test_free_run();
      do_reset();
      for (int i = 0; i < 17; i++) tick();
      checks++; if ({out_valid, out_instr, out_pc, out_pc8} !== {1'b1, 32'hE5A90008, 32'd64, 32'd72})
         begin errors++; $display("FAIL run_last got=%b %h %h %h exp=1 e5a90008 64 72", out_valid, out_instr, out_pc, out_pc8); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL run_done_early got=%b exp=0", done); end
      tick();
      checks++; if ({out_valid, done, imem_addr, fetch_count} !== {1'b0, 1'b1, 32'd68, 16'd17})
         begin errors++; $display("FAIL run_end got=%b %b %h %0d exp=0 1 44 17", out_valid, done, imem_addr, fetch_count); end
      for (int i = 0; i < 3; i++) tick();
      checks++; if ({out_valid, done, imem_addr, fetch_count} !== {1'b0, 1'b1, 32'd68, 16'd17})
         begin errors++; $display("FAIL run_idle got=%b %b %h %0d exp=0 1 44 17", out_valid, done, imem_addr, fetch_count); end
   endtask

   task automatic test_branch_drop();
      do_reset();
      for (int i = 0; i < 4; i++) tick();
      out_ready = 1'b0;
      tick();
      checks++; if ({out_valid, out_pc, fetch_count} !== {1'b1, 32'd12, 16'd3})
         begin errors++; $display("FAIL held12 got=%b %h %0d exp=1 c 3", out_valid, out_pc, fetch_count); end
      // Accept coinciding with the branch must not count.
      out_ready = 1'b1; branch_valid = 1'b1; branch_target = 32'd60;
      tick();
      branch_valid = 1'b0;
      checks++; if ({out_valid, imem_addr, fetch_count, misalign} !== {1'b0, 32'd60, 16'd3, 1'b0})
         begin errors++; $display("FAIL branch_drop got=%b %h %0d %b exp=0 3c 3 0", out_valid, imem_addr, fetch_count, misalign); end
      tick();
      checks++; if ({out_valid, out_instr, out_pc, fetch_count} !== {1'b1, 32'h1AFFFFFB, 32'd60, 16'd3})
         begin errors++; $display("FAIL branch_target got=%b %h %h %0d exp=1 1afffffb 3c 3", out_valid, out_instr, out_pc, fetch_count); end
   endtask

   task automatic test_branch_from_done();
      test_free_run();
      branch_valid = 1'b1; branch_target = 32'h3E;
      tick();
      branch_valid = 1'b0;
      checks++; if ({imem_addr, misalign, done, out_valid} !== {32'h3C, 1'b1, 1'b0, 1'b0})
         begin errors++; $display("FAIL done_branch got=%h %b %b %b exp=3c 1 0 0", imem_addr, misalign, done, out_valid); end
      tick();
      checks++; if ({out_valid, out_instr, out_pc} !== {1'b1, 32'h1AFFFFFB, 32'h3C})
         begin errors++; $display("FAIL resume got=%b %h %h exp=1 1afffffb 3c", out_valid, out_instr, out_pc); end
      tick();
      checks++; if ({out_instr, misalign, fetch_count} !== {32'hE5A90008, 1'b1, 16'd18})
         begin errors++; $display("FAIL sticky got=%h %b %0d exp=e5a90008 1 18", out_instr, misalign, fetch_count); end
      // Mid-run reset beats a simultaneous branch.
      reset = 1'b1; branch_valid = 1'b1; branch_target = 32'h3E;
      tick();
      checks++; if ({out_valid, out_instr, out_pc, imem_addr, done, misalign, fetch_count} !== 115'd0)
         begin errors++; $display("FAIL midrun_reset got=%b %h %h %h %b %b %0d exp=all zero", out_valid, out_instr, out_pc, imem_addr, done, misalign, fetch_count); end
      reset = 1'b0; branch_valid = 1'b0;
   endtask

   task automatic test_wrap();
      do_reset();
      branch_valid = 1'b1; branch_target = 32'hFFFF_FFFC;
      tick();
      branch_valid = 1'b0;
      tick();
      checks++; if ({out_pc, out_pc8, imem_addr} !== {32'hFFFF_FFFC, 32'd4, 32'd0})
         begin errors++; $display("FAIL wrap got=%h %h %h exp=fffffffc 4 0", out_pc, out_pc8, imem_addr); end
      tick();
      checks++; if ({out_instr, out_pc} !== {32'hE2099F00, 32'd0})
         begin errors++; $display("FAIL wrap_next got=%h %h exp=e2099f00 0", out_instr, out_pc); end
   endtask

   initial begin
      test_reset();
      test_first_fetch();
      test_stall();
      test_free_run();
      test_branch_drop();
      test_branch_from_done();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 RESET_PC, 32'd0: byte address fetched first after reset.
REQ-002 END_WORD, 32'd0: instruction word treated as end-of-program marker.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imem_addr  output  32  byte address to instruction memory; always a multiple of 4.
REQ-006 imem_data  input  32  instruction word; combinational from memory, valid in the same cycle as imem_addr.
REQ-007 branch_valid  input  1  redirect request; one-cycle pulse.
REQ-008 branch_target  input  32  redirect byte address.
REQ-009 out_valid  output  1  out_instr/out_pc hold a fetched instruction.
REQ-010 out_ready  input  1  consumer accepts the instruction when out_valid=1 on the same edge.
REQ-011 out_instr  output  32  fetched instruction word.
REQ-012 out_pc  output  32  byte address of out_instr.
REQ-013 out_pc8  output  32  out_pc+8, the ARM-visible PC value.
REQ-014 done  output  1  end marker reached; fetching halted.
REQ-015 misalign  output  1  sticky flag: a branch_target had bits [1:0]≠0.
REQ-016 fetch_count  output  16  count of accepted instructions; saturates at 16'hFFFF.

Function
REQ-017 States: FETCH and DONE.
- FETCH: issue instructions.
- DONE: idle until branch or reset.
REQ-018 imem_addr shall equal the registered pc at all times.
REQ-019 Capture in FETCH when branch_valid=0 and (out_valid=0 or out_ready=1), and imem_data≠END_WORD:
- out_instr<=imem_data, out_pc<=pc, out_valid<=1, pc<=pc+4.
REQ-020 Hold when out_valid=1 and out_ready=0 (no branch): pc and all output registers are held.
REQ-021 End marker: a capture condition with imem_data==END_WORD shall:
- set out_valid<=0 (unless a held instruction is still unaccepted);
- hold pc on the marker address;
- enter DONE with done=1 on the next cycle.
REQ-022 Branch, any state, branch_valid=1:
- pc<={branch_target[31:2],2'b00};
- out_valid<=0, so the held instruction is discarded and not counted;
- state<=FETCH, done<=0.
Branch has priority over capture, hold and end-marker handling.
REQ-023 misalign shall set on a branch whose target[1:0]≠0 and remain set until reset.
REQ-024 fetch_count shall increment on every edge with out_valid=1 and out_ready=1, including the edge on which a branch arrives only if that branch is absent; an accept coinciding with a branch is not counted.
REQ-025 Latency: an instruction shall appear on out_* one cycle after its address is on imem_addr; with out_ready held at 1, throughput is one instruction per cycle.
REQ-026 pc+4 shall wrap modulo 2^32.
REQ-027 out_pc8 shall be combinational out_pc+8, modulo 2^32.

Reset
REQ-028 reset=1 at an edge shall set:
- pc=RESET_PC, state=FETCH;
- out_valid=0, out_instr=0, out_pc=0;
- done=0, misalign=0, fetch_count=0.
Reset overrides branch and takes effect mid-operation from any state.

Structure
REQ-029 State encoding, RESET_PC and END_WORD defaults and the PC increment constant 4 shall live in the shared CPU constants package.
REQ-030 One sub-module is natural: fetch_out_reg, the valid/ready output register with hold. The pc/FSM logic stays in instruction_fetch.

Verification
All scenarios use the team's program memory model (addr 0=E2099F00, 4=E3811F06, 60=1AFFFFFB, 64=E5A90008, 68=0).
REQ-031 Reset release, out_ready=1: cycle 1 gives out_instr=E2099F00 with out_pc=0 and out_pc8=8; cycle 2 gives E3811F06 with out_pc=4.
REQ-032 out_ready=0 for 3 cycles while E3811F06 is valid: out_* and imem_addr=8 are stable throughout; fetch_count increments exactly once after out_ready returns to 1.
REQ-033 Free run from 0: the last valid instruction is E5A90008 at out_pc=64; imem_addr stays at 68; done=1; fetch_count=17; out_valid stays 0.
REQ-034 branch_valid with target=60 while the instruction at 12 is held unaccepted: the held instruction is dropped and not counted; next out_instr=1AFFFFFB at out_pc=60.
REQ-035 Branch target=0x3E in DONE: imem_addr=0x3C, misalign=1, done=0, fetch resumes at 1AFFFFFB; reset asserted mid-run clears every output to its reset value on the next edge.
